// File: rtl/pong_comm_pkg.sv
// Shared message classes, payload layouts and default link timing for the pong comm link.
package pong_comm_pkg;

    typedef enum logic [1:0] {
        BALL         = 2'd0,
        MISS         = 2'd1,
        NEW_GAME     = 2'd2,
        NEW_GAME_ACK = 2'd3
    } msg_class_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } tx_state_t;

    localparam int BALL_Y_W = 9;
    localparam int VEL_W    = 4;
    localparam int SCORE_W  = 5;

    localparam int DEF_RETRY_CYCLES = 5_000_000;
    localparam int DEF_MAX_RETRIES  = 8;

    typedef struct packed {
        logic [BALL_Y_W-1:0] ball_y;
        logic [VEL_W-1:0]    vel_x;
        logic [VEL_W-1:0]    vel_y;
    } ball_pl_t;

    typedef struct packed {
        logic [SCORE_W-1:0] my_score;
        logic [SCORE_W-1:0] your_score;
        logic               you_should_serve;
    } miss_pl_t;

endpackage

// File: rtl/ack_retry_timer.sv
// New-game acknowledge tracking: ack timeout timer, saturating retry counter, link status.
// retry_req is combinational in the expiry cycle; no backpressure.
module ack_retry_timer
    import pong_comm_pkg::*;
#(
    parameter int RETRY_CYCLES = DEF_RETRY_CYCLES,
    parameter int MAX_RETRIES  = DEF_MAX_RETRIES
) (
    input  logic CLOCK_50,
    input  logic reset,
    input  logic start,
    input  logic restart,
    input  logic ack_rx,
    output logic awaiting_ack,
    output logic game_linked,
    output logic link_failed,
    output logic retry_req
);

    localparam int TW = (RETRY_CYCLES > 1) ? $clog2(RETRY_CYCLES) : 1;
    localparam int CW = $clog2(MAX_RETRIES + 1);

    logic [TW-1:0] timer_q, timer_d;
    logic [CW-1:0] count_q, count_d;
    logic          awaiting_q, awaiting_d;
    logic          linked_q, linked_d;
    logic          failed_q, failed_d;
    logic          expire;

    assign expire = awaiting_q && (timer_q == TW'(RETRY_CYCLES - 1));

    always_comb begin
        timer_d    = timer_q;
        count_d    = count_q;
        awaiting_d = awaiting_q;
        linked_d   = linked_q;
        failed_d   = failed_q;
        retry_req  = 1'b0;

        if (awaiting_q) timer_d = timer_q + TW'(1);

        // An ack landing in the expiry cycle takes precedence over the retry.
        if (awaiting_q && ack_rx) begin
            awaiting_d = 1'b0;
            linked_d   = 1'b1;
            timer_d    = '0;
        end else if (expire) begin
            awaiting_d = 1'b0;
            timer_d    = '0;
            if (count_q != CW'(MAX_RETRIES)) count_d = count_q + CW'(1);
            if ((int'(count_q) + 1) < MAX_RETRIES) retry_req = 1'b1;
            else                                   failed_d  = 1'b1;
        end

        if (start) begin
            awaiting_d = 1'b1;
            timer_d    = '0;
        end

        if (restart) begin
            awaiting_d = 1'b0;
            linked_d   = 1'b0;
            failed_d   = 1'b0;
            count_d    = '0;
            timer_d    = '0;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            timer_q    <= '0;
            count_q    <= '0;
            awaiting_q <= 1'b0;
            linked_q   <= 1'b0;
            failed_q   <= 1'b0;
        end else begin
            timer_q    <= timer_d;
            count_q    <= count_d;
            awaiting_q <= awaiting_d;
            linked_q   <= linked_d;
            failed_q   <= failed_d;
        end
    end

    assign awaiting_ack = awaiting_q;
    assign game_linked  = linked_q;
    assign link_failed  = failed_q;

endmodule

// File: rtl/comm_tx_scheduler.sv
// Arbitrates game messages onto the serial sender, fixed priority ack > new_game > miss > ball.
// Grant-to-send_new_message latency 1 cycle; message held until message_sent, one idle cycle between messages.
module comm_tx_scheduler
    import pong_comm_pkg::*;
#(
    parameter int RETRY_CYCLES = DEF_RETRY_CYCLES,
    parameter int MAX_RETRIES  = DEF_MAX_RETRIES
) (
    input  logic                CLOCK_50,
    input  logic                reset,
    input  logic                ball_req,
    input  logic                miss_req,
    input  logic                new_game_req,
    input  logic                ack_req,
    input  logic [BALL_Y_W-1:0] ball_y_in,
    input  logic [VEL_W-1:0]    velocity_x_in,
    input  logic [VEL_W-1:0]    velocity_y_in,
    input  logic [SCORE_W-1:0]  my_score_in,
    input  logic [SCORE_W-1:0]  your_score_in,
    input  logic                you_should_serve_in,
    input  logic                you_serve_first_in,
    input  logic                new_game_ack_rx,
    output logic                send_new_message,
    input  logic                message_sent,
    output logic                ball_message_tx,
    output logic                miss_message_tx,
    output logic                new_game_message_tx,
    output logic                new_game_ack_message_tx,
    output logic [BALL_Y_W-1:0] ball_y_tx,
    output logic [VEL_W-1:0]    velocity_x_tx,
    output logic [VEL_W-1:0]    velocity_y_tx,
    output logic [SCORE_W-1:0]  my_score_tx,
    output logic [SCORE_W-1:0]  your_score_tx,
    output logic                you_should_serve_tx,
    output logic                you_serve_first_tx,
    output logic                game_linked,
    output logic                link_failed,
    output logic                tx_idle
);

    tx_state_t  state_q, state_d;
    msg_class_t cls_q, cls_d;
    logic [3:0] pend_q, pend_d;
    ball_pl_t   ball_pl_q, ball_pl_d, out_ball_q, out_ball_d;
    miss_pl_t   miss_pl_q, miss_pl_d, out_miss_q, out_miss_d;
    logic       ysf_q, ysf_d, out_ysf_q, out_ysf_d;

    logic       grant_vld;
    msg_class_t grant_cls;
    logic       data_ok;
    logic       ng_done;
    logic       awaiting_ack;
    logic       retry_req;

    // Game-data traffic only flows on an acknowledged link with no handshake in flight.
    assign data_ok = game_linked && !awaiting_ack;
    assign ng_done = (state_q == ST_SEND) && message_sent && (cls_q == NEW_GAME);

    always_comb begin
        grant_vld = 1'b0;
        grant_cls = BALL;
        if (pend_q[NEW_GAME_ACK]) begin
            grant_vld = 1'b1;
            grant_cls = NEW_GAME_ACK;
        end else if (pend_q[NEW_GAME]) begin
            grant_vld = 1'b1;
            grant_cls = NEW_GAME;
        end else if (pend_q[MISS] && data_ok) begin
            grant_vld = 1'b1;
            grant_cls = MISS;
        end else if (pend_q[BALL] && data_ok) begin
            grant_vld = 1'b1;
            grant_cls = BALL;
        end
    end

    always_comb begin
        pend_d     = pend_q;
        ball_pl_d  = ball_pl_q;
        miss_pl_d  = miss_pl_q;
        ysf_d      = ysf_q;
        state_d    = state_q;
        cls_d      = cls_q;
        out_ball_d = out_ball_q;
        out_miss_d = out_miss_q;
        out_ysf_d  = out_ysf_q;

        unique case (state_q)
            ST_IDLE: begin
                if (grant_vld) begin
                    state_d           = ST_SEND;
                    cls_d             = grant_cls;
                    pend_d[grant_cls] = 1'b0;
                    case (grant_cls)
                        BALL:     out_ball_d = ball_pl_q;
                        MISS:     out_miss_d = miss_pl_q;
                        NEW_GAME: out_ysf_d  = ysf_q;
                        default:  ;
                    endcase
                end
            end
            ST_SEND: begin
                if (message_sent) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Captures come after the grant clear so a same-cycle request stays pending.
        if (ball_req) begin
            pend_d[BALL] = 1'b1;
            ball_pl_d    = '{ball_y: ball_y_in, vel_x: velocity_x_in, vel_y: velocity_y_in};
        end
        if (miss_req) begin
            pend_d[MISS] = 1'b1;
            miss_pl_d    = '{my_score: my_score_in, your_score: your_score_in,
                             you_should_serve: you_should_serve_in};
        end
        if (ack_req) pend_d[NEW_GAME_ACK] = 1'b1;
        if (retry_req) pend_d[NEW_GAME] = 1'b1;
        if (new_game_req) begin
            pend_d[NEW_GAME] = 1'b1;
            ysf_d            = you_serve_first_in;
            pend_d[BALL]     = 1'b0;
            pend_d[MISS]     = 1'b0;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cls_q      <= BALL;
            pend_q     <= '0;
            ball_pl_q  <= '0;
            miss_pl_q  <= '0;
            ysf_q      <= 1'b0;
            out_ball_q <= '0;
            out_miss_q <= '0;
            out_ysf_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cls_q      <= cls_d;
            pend_q     <= pend_d;
            ball_pl_q  <= ball_pl_d;
            miss_pl_q  <= miss_pl_d;
            ysf_q      <= ysf_d;
            out_ball_q <= out_ball_d;
            out_miss_q <= out_miss_d;
            out_ysf_q  <= out_ysf_d;
        end
    end

    ack_retry_timer #(
        .RETRY_CYCLES (RETRY_CYCLES),
        .MAX_RETRIES  (MAX_RETRIES)
    ) u_ack_retry_timer (
        .CLOCK_50     (CLOCK_50),
        .reset        (reset),
        .start        (ng_done),
        .restart      (new_game_req),
        .ack_rx       (new_game_ack_rx),
        .awaiting_ack (awaiting_ack),
        .game_linked  (game_linked),
        .link_failed  (link_failed),
        .retry_req    (retry_req)
    );

    assign send_new_message        = (state_q == ST_SEND);
    assign ball_message_tx         = send_new_message && (cls_q == BALL);
    assign miss_message_tx         = send_new_message && (cls_q == MISS);
    assign new_game_message_tx     = send_new_message && (cls_q == NEW_GAME);
    assign new_game_ack_message_tx = send_new_message && (cls_q == NEW_GAME_ACK);

    assign ball_y_tx           = out_ball_q.ball_y;
    assign velocity_x_tx       = out_ball_q.vel_x;
    assign velocity_y_tx       = out_ball_q.vel_y;
    assign my_score_tx         = out_miss_q.my_score;
    assign your_score_tx       = out_miss_q.your_score;
    assign you_should_serve_tx = out_miss_q.you_should_serve;
    assign you_serve_first_tx  = out_ysf_q;

    assign tx_idle = (state_q == ST_IDLE) && (pend_q == '0);

endmodule
